gcd_rr_scheduler: RTL
=====================

GCD_RR_SCHEDULER -- requirements
Module: gcd_rr_scheduler

Interface
REQ-001 Parameter N, default 4: number of requesters (2..8).
REQ-002 Parameter W, default 4: operand and result width, matching the GCD engine.
REQ-003 Parameter TIMEOUT, default 64: maximum number of WAIT cycles before the job is aborted.
REQ-004 The clock and reset SHALL be one clock and a synchronous active-high reset: clk and reset.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  synchronous, active-high, sampled on the clk rising edge.
REQ-007 req  in  N  per-requester level request; held until ack.
REQ-008 op_a  in  N*W  packed operand A; requester i uses bits [i*W +: W].
REQ-009 op_b  in  N*W  packed operand B, same packing as op_a.
REQ-010 ack  out  N  one-hot, one-cycle completion pulse to the granted requester.
REQ-011 result  out  W  GCD result; valid only while any ack bit is 1.
REQ-012 err  out  1  timeout flag; valid only while any ack bit is 1.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 grant_id  out  clog2(N)  index of the current or last granted requester.
REQ-015 eng_start  out  1  one-cycle start pulse to the GCD engine.
REQ-016 eng_in1, eng_in2  out  W each  engine operands, driven from the latched operands.
REQ-017 eng_done  in  1  engine done pulse.
REQ-018 eng_gcd  in  W  engine result, valid on the cycle after eng_done.

Function
REQ-019 The states SHALL be IDLE, ISSUE, WAIT, CAPT and RESP, held in registered state.
REQ-020 IDLE: when any req bit is 1, the block SHALL grant the first asserted requester found by a round-robin search that starts at last_grant+1 and wraps modulo N.
REQ-021 On the grant edge the block SHALL update grant_id and last_grant, and latch op_a and op_b of the granted requester into internal registers.
REQ-022 If either latched operand is 0, the next state SHALL be RESP with result = A | B; this bypass gives gcd(x,0)=x and gcd(0,0)=0, and eng_start is never asserted.
REQ-023 Otherwise the next state SHALL be ISSUE.
REQ-024 ISSUE: eng_start SHALL be 1 for exactly one cycle, then the next state SHALL be WAIT.
REQ-025 eng_in1 and eng_in2 SHALL hold the latched operands continuously from ISSUE until leaving CAPT.
REQ-026 WAIT: when eng_done=1 the next state SHALL be CAPT.
REQ-027 In WAIT a W-independent cycle counter SHALL increment every cycle; when it reaches TIMEOUT-1 without eng_done, the next state SHALL be RESP with err=1 and result=0.
REQ-028 CAPT: the block SHALL register eng_gcd into the result register for one cycle, then go to RESP.
REQ-029 RESP: for exactly one cycle, ack[grant_id]=1, result and err SHALL be valid, then the next state SHALL be IDLE.
REQ-030 A requester SHALL drop req on the cycle after its ack; a req still high in IDLE is treated as a new request.
REQ-031 req changes while busy SHALL be ignored; operand changes after the grant edge SHALL NOT affect the job.
REQ-032 eng_done outside WAIT SHALL be ignored.
REQ-033 The WAIT counter SHALL clear on entry to WAIT.
REQ-034 Latency, bypass path: the grant edge occurs in IDLE and ack is asserted in the next cycle.
REQ-035 Latency, normal path: ISSUE(1) + WAIT(k, until eng_done) + CAPT(1) + RESP, so ack comes 2 cycles after the eng_done cycle.
REQ-036 Only one job SHALL be in flight at a time; there is no queueing beyond the req lines.

Reset
REQ-037 While reset=1 at a clk edge: state=IDLE, ack=0, result=0, err=0, busy=0, eng_start=0, eng_in1=eng_in2=0, grant_id=0, and the WAIT counter = 0.
REQ-038 last_grant SHALL reset to N-1, so requester 0 has first priority.
REQ-039 Reset asserted in any state, including mid-WAIT, SHALL abort the job with no ack; a later stray eng_done SHALL be ignored.

Verification (engine = team GCD engine unless noted)
REQ-040 Single request: req[0] with (12,8) -> one ack[0] pulse, result=4, err=0, eng_start pulsed exactly once.
REQ-041 Simultaneous requests: req[3:0]=1111 with (12,8),(9,6),(7,7),(15,10) -> acks in order 0,1,2,3 with results 4,3,7,5; re-request 1010 -> order 1 then 3.
REQ-042 Zero bypass: req[2] with (9,0) -> ack[2] one cycle after the grant, result=9; (0,0) -> result=0; eng_start stays 0 for both.
REQ-043 Timeout: stub engine never asserts eng_done, TIMEOUT=16 -> ack after 16 WAIT cycles with err=1 and result=0; the next request proceeds normally.
REQ-044 Reset mid-WAIT: reset for 1 cycle -> busy=0, no ack; the stub then pulses eng_done and the block stays IDLE; the next req[0] with (12,8) -> result=4.
REQ-045 Operand hold: op_a/op_b change on the cycle after the grant -> result reflects the latched values, and eng_in1/eng_in2 stay stable through CAPT.

Source files
------------

// File: rtl/gcd_rr_scheduler.sv
// Round-robin front end for a shared GCD engine: grants one requester at a time,
// bypasses zero operands, drives the engine, and returns the result with an ack pulse.
module gcd_rr_scheduler #(
  parameter int N       = 4,
  parameter int W       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       op_a,
  input  logic [N*W-1:0]       op_b,
  output logic [N-1:0]         ack,
  output logic [W-1:0]         result,
  output logic                 err,
  output logic                 busy,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 eng_start,
  output logic [W-1:0]         eng_in1,
  output logic [W-1:0]         eng_in2,
  input  logic                 eng_done,
  input  logic [W-1:0]         eng_gcd
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CAPT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] last_grant_q, last_grant_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  result_q, result_d;
  logic          err_q, err_d;
  logic [N-1:0]  ack_q, ack_d;
  logic          eng_start_q, eng_start_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] sel_s;
  logic [W-1:0]  op_a_s [N];
  logic [W-1:0]  op_b_s [N];

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
    logic [N-1:0] v;
    v      = {N{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign op_a_s[g] = op_a[g*W +: W];
    assign op_b_s[g] = op_b[g*W +: W];
  end

  // Round-robin pick: scan downward so the nearest requester after last_grant wins.
  always_comb begin
    sel_s = {IW{1'b0}};
    for (int i = N; i >= 1; i--) begin
      logic [IW-1:0] cand;
      cand  = IW'((int'(last_grant_q) + i) % N);
      sel_s = req[cand] ? cand : sel_s;
    end
  end

  // Job sequencing and next-value computation for every register.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    err_d        = err_q;
    ack_d        = {N{1'b0}};
    eng_start_d  = 1'b0;
    cnt_d        = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_id_d   = sel_s;
          last_grant_d = sel_s;
          a_d          = op_a_s[sel_s];
          b_d          = op_b_s[sel_s];
          err_d        = 1'b0;
          // A zero operand makes the answer the other operand; skip the engine.
          if ((a_d == {W{1'b0}}) || (b_d == {W{1'b0}})) begin
            state_d  = S_RESP;
            result_d = a_d | b_d;
            ack_d    = onehot(sel_s);
          end else begin
            state_d     = S_ISSUE;
            eng_start_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = {CW{1'b0}};
      end
      S_WAIT: begin
        if (eng_done) begin
          state_d = S_CAPT;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d  = S_RESP;
          err_d    = 1'b1;
          result_d = {W{1'b0}};
          ack_d    = onehot(grant_id_q);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CAPT: begin
        state_d  = S_RESP;
        result_d = eng_gcd;
        ack_d    = onehot(grant_id_q);
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= IW'(N - 1);
      grant_id_q   <= {IW{1'b0}};
      a_q          <= {W{1'b0}};
      b_q          <= {W{1'b0}};
      result_q     <= {W{1'b0}};
      err_q        <= 1'b0;
      ack_q        <= {N{1'b0}};
      eng_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      cnt_q        <= {CW{1'b0}};
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      err_q        <= err_d;
      ack_q        <= ack_d;
      eng_start_q  <= eng_start_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ack       = ack_q;
  assign result    = result_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;
  assign eng_start = eng_start_q;
  assign eng_in1   = a_q;
  assign eng_in2   = b_q;

endmodule
